// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter_if
// Brief    : Request/grant and mux-select bundle between four requesters and
//            the round-robin arbiter that steers the shared 4:1 data mux.
// Revision : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       S0;
  logic       S1;
  logic       BUS_VALID;
  logic       LAST_BEAT;

  // Arbiter side: consumes requests, drives grant and mux select.
  modport master (
    input  REQ,
    output GNT,
    output S0,
    output S1,
    output BUS_VALID,
    output LAST_BEAT
  );

  // Requester side.
  modport slave (
    output REQ,
    input  GNT,
    input  S0,
    input  S1,
    input  BUS_VALID,
    input  LAST_BEAT
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter for a shared 4-bit 4:1 mux with a per-tenure
//            beat limit and a fixed turnaround gap between owners.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int MAX_BEATS  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  mux4_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] c_max_beats   = 4'(MAX_BEATS);
  localparam logic [3:0] c_gap_cycles  = 4'(GAP_CYCLES);
  localparam logic       c_single_beat = (MAX_BEATS == 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;
  logic       r_last;
  logic [3:0] r_beat;
  logic [3:0] r_gap;
  logic [1:0] r_ptr;

  logic       w_any;
  logic [1:0] w_win;
  logic       w_release;
  logic       w_gap_done;

  // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    f_pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) f_pick = idx;
    end
  endfunction

  always_comb begin
    w_any      = |bus.REQ;
    w_win      = f_pick(bus.REQ, r_ptr);
    w_release  = !bus.REQ[r_sel] || (r_beat == c_max_beats);
    w_gap_done = (r_gap == c_gap_cycles);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_beat  <= 4'd0;
      r_gap   <= 4'd0;
      r_ptr   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_beat  <= 4'd1;
            r_last  <= c_single_beat;
          end
        end

        ST_GRANT: begin
          // Owner drop and beat-limit expiry collapse into one release.
          if (w_release) begin
            r_state <= ST_GAP;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ptr   <= r_sel + 2'd1;
            r_gap   <= 4'd1;
          end else begin
            r_beat  <= r_beat + 4'd1;
            r_last  <= ((r_beat + 4'd1) == c_max_beats);
          end
        end

        ST_GAP: begin
          if (w_gap_done) begin
            if (w_any) begin
              r_state <= ST_GRANT;
              r_gnt   <= 4'b0001 << w_win;
              r_sel   <= w_win;
              r_valid <= 1'b1;
              r_beat  <= 4'd1;
              r_last  <= c_single_beat;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Select lines are only written on a new grant, so they hold through GAP/IDLE.
  assign bus.GNT       = r_gnt;
  assign bus.S1        = r_sel[1];
  assign bus.S0        = r_sel[0];
  assign bus.BUS_VALID = r_valid;
  assign bus.LAST_BEAT = r_last;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed-vector bench for mux4_rr_arbiter (MAX_BEATS 8 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mux4_rr_arbiter_if b8 ();
  mux4_rr_arbiter_if b4 ();

  mux4_rr_arbiter #(.MAX_BEATS(8), .GAP_CYCLES(1)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (b8.master)
  );

  mux4_rr_arbiter #(.MAX_BEATS(4), .GAP_CYCLES(1)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (b4.master)
  );

  // Observed vectors packed as {GNT, S1, S0, BUS_VALID, LAST_BEAT}.
  logic [7:0] obs8;
  logic [7:0] obs4;
  assign obs8 = {b8.GNT, b8.S1, b8.S0, b8.BUS_VALID, b8.LAST_BEAT};
  assign obs4 = {b4.GNT, b4.S1, b4.S0, b4.BUS_VALID, b4.LAST_BEAT};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    b8.REQ = 4'b1111;
    b4.REQ = 4'b1111;
    RST    = 1'b1;
    tick();
    tick();
    checks++;
    if (obs8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut8: got gnt_s_bv_lb=%b expected %b", obs8, 8'h00);
    end
    checks++;
    if (obs4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut4: got gnt_s_bv_lb=%b expected %b", obs4, 8'h00);
    end
    b8.REQ = 4'b0000;
    b4.REQ = 4'b0000;
    RST    = 1'b0;
    tick();
  endtask

  task automatic test_single_tenure();
    logic [7:0] exp;
    b8.REQ = 4'b0100;
    for (int beat = 1; beat <= 3; beat++) begin
      tick();
      exp = {4'b0100, 2'b10, 1'b1, 1'b0};
      checks++;
      if (obs8 !== exp) begin
        errors++;
        $display("FAIL single_beat%0d: got %b expected %b", beat, obs8, exp);
      end
    end
    b8.REQ = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp = {4'b0000, 2'b10, 1'b0, 1'b0};
      checks++;
      if (obs8 !== exp) begin
        errors++;
        $display("FAIL single_after%0d: got %b expected %b", c, obs8, exp);
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    logic [1:0] own;
    do_reset();
    b8.REQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      own = 2'(t);
      for (int beat = 1; beat <= 8; beat++) begin
        tick();
        exp = {4'b0001 << own, own, 1'b1, (beat == 8)};
        checks++;
        if (obs8 !== exp) begin
          errors++;
          $display("FAIL rotation t%0d beat%0d: got %b expected %b", t, beat, obs8, exp);
        end
      end
      tick();
      exp = {4'b0000, own, 1'b0, 1'b0};
      checks++;
      if (obs8 !== exp) begin
        errors++;
        $display("FAIL rotation_gap t%0d: got %b expected %b", t, obs8, exp);
      end
    end
    b8.REQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_pointer_skip();
    logic [7:0] exp;
    do_reset();
    b8.REQ = 4'b0010;
    tick();
    exp = {4'b0010, 2'b01, 1'b1, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL skip_owner1: got %b expected %b", obs8, exp);
    end
    b8.REQ = 4'b1001;
    tick();
    exp = {4'b0000, 2'b01, 1'b0, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL skip_release1: got %b expected %b", obs8, exp);
    end
    tick();
    exp = {4'b1000, 2'b11, 1'b1, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL skip_grant3: got %b expected %b", obs8, exp);
    end
    b8.REQ = 4'b0001;
    tick();
    exp = {4'b0000, 2'b11, 1'b0, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL skip_release3: got %b expected %b", obs8, exp);
    end
    tick();
    exp = {4'b0001, 2'b00, 1'b1, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL skip_grant0: got %b expected %b", obs8, exp);
    end
    b8.REQ = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_coincident_drop();
    logic [7:0] exp;
    do_reset();
    b4.REQ = 4'b0011;
    for (int beat = 1; beat <= 4; beat++) begin
      tick();
      exp = {4'b0001, 2'b00, 1'b1, (beat == 4)};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL coincide_beat%0d: got %b expected %b", beat, obs4, exp);
      end
    end
    // Owner drops on the limit edge; 1 and 2 requesting exposes a double PTR step.
    b4.REQ = 4'b0110;
    tick();
    exp = {4'b0000, 2'b00, 1'b0, 1'b0};
    checks++;
    if (obs4 !== exp) begin
      errors++;
      $display("FAIL coincide_release: got %b expected %b", obs4, exp);
    end
    tick();
    exp = {4'b0010, 2'b01, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin
      errors++;
      $display("FAIL coincide_next: got %b expected %b", obs4, exp);
    end
    b4.REQ = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_timeout_regrant();
    logic [7:0] exp;
    do_reset();
    b4.REQ = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      for (int beat = 1; beat <= 4; beat++) begin
        tick();
        exp = {4'b0100, 2'b10, 1'b1, (beat == 4)};
        checks++;
        if (obs4 !== exp) begin
          errors++;
          $display("FAIL timeout r%0d beat%0d: got %b expected %b", r, beat, obs4, exp);
        end
      end
      tick();
      exp = {4'b0000, 2'b10, 1'b0, 1'b0};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL timeout_gap r%0d: got %b expected %b", r, obs4, exp);
      end
    end
    b4.REQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    do_reset();
    b8.REQ = 4'b1111;
    for (int c = 0; c < 9; c++) tick();
    tick();
    exp = {4'b0010, 2'b01, 1'b1, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL areset_tenure2: got %b expected %b", obs8, exp);
    end
    tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if (obs8 !== 8'h00) begin
      errors++;
      $display("FAIL areset_immediate: got %b expected %b", obs8, 8'h00);
    end
    tick();
    checks++;
    if (obs8 !== 8'h00) begin
      errors++;
      $display("FAIL areset_held: got %b expected %b", obs8, 8'h00);
    end
    RST = 1'b0;
    tick();
    exp = {4'b0001, 2'b00, 1'b1, 1'b0};
    checks++;
    if (obs8 !== exp) begin
      errors++;
      $display("FAIL areset_first_grant: got %b expected %b", obs8, exp);
    end
    b8.REQ = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  initial begin
    b8.REQ = 4'b0000;
    b4.REQ = 4'b0000;
    test_reset();
    test_single_tenure();
    test_rotation();
    test_pointer_skip();
    test_coincident_drop();
    test_timeout_regrant();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
